// File: rtl/conv_pass_sequencer.sv
// Pass/address sequencer for the convolution datapath: walks pass x address with
// stall hold and abort cancel, then waits out the MAC pipeline before pulsing done.
module conv_pass_sequencer #(
    parameter int N_PASSES  = 4,
    parameter int PASS_LEN  = 36,
    parameter int DRAIN_CYC = 2,
    parameter int PASS_W    = (N_PASSES > 1) ? $clog2(N_PASSES) : 1,
    parameter int ADDR_W    = $clog2(PASS_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PASS_W:0]   n_passes_cfg,
    input  logic              stall,
    input  logic              abort,
    output logic [PASS_W-1:0] dir,
    output logic [ADDR_W-1:0] dir_counter,
    output logic              addr_valid,
    output logic              first_addr,
    output logic              last_addr,
    output logic              last_pass,
    output logic              busy_proc,
    output logic              done
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PASS_W:0]    CFG_MAX    = (PASS_W+1)'(N_PASSES);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(PASS_LEN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    logic [1:0]         r_state;
    logic [PASS_W-1:0]  r_dir;
    logic [ADDR_W-1:0]  r_cnt;
    logic [DRAIN_W-1:0] r_drain;
    logic [PASS_W:0]    r_cfg;

    logic [1:0]         w_state_nxt;
    logic [PASS_W-1:0]  w_dir_nxt;
    logic [ADDR_W-1:0]  w_cnt_nxt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic [PASS_W:0]    w_cfg_nxt;

    logic [PASS_W:0]    w_cfg_clamped;
    logic [PASS_W:0]    w_cfg_last;
    logic               w_last_pass;
    logic               w_end_of_pass;

    // Zero or out-of-range pass counts fall back to the full job.
    assign w_cfg_clamped = ((n_passes_cfg == '0) || (n_passes_cfg > CFG_MAX)) ? CFG_MAX : n_passes_cfg;
    assign w_cfg_last    = r_cfg - (PASS_W+1)'(1);
    assign w_last_pass   = ({1'b0, r_dir} == w_cfg_last);
    assign w_end_of_pass = (r_cnt == ADDR_LAST);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        w_cfg_nxt   = r_cfg;

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_dir_nxt   = '0;
            w_cnt_nxt   = '0;
            w_drain_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_cfg_nxt   = w_cfg_clamped;
                        w_dir_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_drain_nxt = '0;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (!w_end_of_pass) begin
                            w_cnt_nxt = r_cnt + ADDR_W'(1);
                        end else begin
                            w_cnt_nxt = '0;
                            if (!w_last_pass) begin
                                w_dir_nxt = r_dir + PASS_W'(1);
                            end else if (DRAIN_CYC == 0) begin
                                w_dir_nxt   = '0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_drain_nxt = '0;
                                w_state_nxt = S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Drain ignores stall: the MAC pipeline empties regardless.
                    if (r_drain == DRAIN_LAST) begin
                        w_drain_nxt = '0;
                        w_dir_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_drain_nxt = r_drain + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    w_dir_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dir   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_cfg   <= CFG_MAX;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drain <= w_drain_nxt;
            r_cfg   <= w_cfg_nxt;
        end
    end

    assign dir         = r_dir;
    assign dir_counter = r_cnt;
    assign busy_proc   = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign addr_valid  = (r_state == S_RUN) && !stall;
    assign first_addr  = addr_valid && (r_cnt == '0);
    assign last_addr   = addr_valid && w_end_of_pass;
    assign last_pass   = (r_state == S_RUN) && w_last_pass;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Directed bench for conv_pass_sequencer: default instance plus a small
// N_PASSES=3 / PASS_LEN=5 / DRAIN_CYC=0 instance, scoreboarded address order.
module tb_conv_pass_sequencer;

    typedef struct packed {
        logic [1:0] p;
        logic [5:0] a;
    } addr_t;

    typedef struct packed {
        logic [1:0] p;
        logic [2:0] a;
    } saddr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, abort;
    logic [2:0] n_passes_cfg;
    logic [1:0] dir;
    logic [5:0] dir_counter;
    logic       addr_valid, first_addr, last_addr, last_pass, busy_proc, done;

    logic       s_start;
    logic [2:0] s_cfg;
    logic [1:0] s_dir;
    logic [2:0] s_cnt;
    logic       s_valid, s_first, s_last, s_lpass, s_busy, s_done;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    addr_t  exp_q[$];
    saddr_t s_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_pass_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .n_passes_cfg(n_passes_cfg),
        .stall(stall), .abort(abort), .dir(dir), .dir_counter(dir_counter),
        .addr_valid(addr_valid), .first_addr(first_addr), .last_addr(last_addr),
        .last_pass(last_pass), .busy_proc(busy_proc), .done(done)
    );

    conv_pass_sequencer #(.N_PASSES(3), .PASS_LEN(5), .DRAIN_CYC(0)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .n_passes_cfg(s_cfg),
        .stall(1'b0), .abort(1'b0), .dir(s_dir), .dir_counter(s_cnt),
        .addr_valid(s_valid), .first_addr(s_first), .last_addr(s_last),
        .last_pass(s_lpass), .busy_proc(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job on the default instance. st_*: stall point/length; ab_*: abort point (-1 = none).
    task automatic run_a(input int cfg, input int cfg_eff, input int st_p, input int st_a,
                         input int st_len, input int ab_p, input int ab_a, input bit ab_stall,
                         input bit hold_start);
        int    t0, stall_left, cur_p, cur_a, n_push, n_valid, lat;
        bit    aborted, finished, keep;
        addr_t e;

        n_push = 0;
        for (int p = 0; p < cfg_eff; p++) begin
            for (int a = 0; a < 36; a++) begin
                keep = (ab_p < 0) || (p < ab_p) || (p == ab_p && a < ab_a) ||
                       (p == ab_p && a == ab_a && !ab_stall);
                if (keep) begin
                    e.p = 2'(p);
                    e.a = 6'(a);
                    exp_q.push_back(e);
                    n_push++;
                end
            end
        end
        lat = cfg_eff * 36 + 2 + st_len;

        n_passes_cfg = 3'(cfg);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        t0 = cyc; stall_left = st_len; cur_p = 0; cur_a = 0;
        n_valid = 0; aborted = 1'b0; finished = 1'b0;

        for (int c = 0; c < 1000 && !finished; c++) begin
            stall = 1'b0;
            abort = 1'b0;
            if (cur_p == st_p && cur_a == st_a && stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end
            if (cur_p == ab_p && cur_a == ab_a && !aborted) begin
                abort   = 1'b1;
                stall   = ab_stall;
                aborted = 1'b1;
            end
            @(negedge clk);
            if (c == 0) check("busy_rise", 32'(busy_proc), 32'd1);
            if (stall && !abort) begin
                check("stall_no_valid", 32'(addr_valid), 32'd0);
                check("stall_hold_pos", 32'({dir, dir_counter}), 32'({2'(st_p), 6'(st_a)}));
            end
            if (addr_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("extra_addr", 32'(addr_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", 32'({dir, dir_counter}), 32'(e));
                    check("first_addr", 32'(first_addr), 32'(e.a == 6'd0));
                    check("last_addr", 32'(last_addr), 32'(e.a == 6'd35));
                    check("last_pass", 32'(last_pass), 32'(e.p == 2'(cfg_eff - 1)));
                end
            end
            if (done) begin
                // done is seen lat edges after the start edge (cycle lat+1 counting that edge's cycle as 1).
                check("done_time", 32'(cyc - t0), 32'(lat));
                check("done_dir_zero", 32'({dir, dir_counter}), 32'd0);
                check("done_busy", 32'(busy_proc), 32'd1);
                finished = 1'b1;
            end
            if (!stall && cur_p < cfg_eff) begin
                if (cur_a == 35) begin
                    cur_a = 0;
                    cur_p++;
                end else begin
                    cur_a++;
                end
            end
            @(posedge clk); #1;
            if (abort) begin
                stall = 1'b0;
                abort = 1'b0;
                @(negedge clk);
                check("abort_busy", 32'(busy_proc), 32'd0);
                check("abort_pos", 32'({dir, dir_counter}), 32'd0);
                check("abort_no_done", 32'(done), 32'd0);
                finished = 1'b1;
            end
        end
        if (!finished) check("job_timeout", 32'(finished), 32'd1);
        check("valid_count", 32'(n_valid), 32'(n_push));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        if (!aborted) begin
            start = 1'b0;
            @(negedge clk);
            check("post_done_idle", 32'(busy_proc), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
        end
        stall = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     t0;
        bit     fin;
        saddr_t se;

        reset = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0; n_passes_cfg = 3'd4;
        s_start = 1'b0; s_cfg = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_proc), 32'd0);
        check("rst_pos", 32'({dir, dir_counter}), 32'd0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_last_pass", 32'(last_pass), 32'd0);
        check("rst_small_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // abort in IDLE blocks a same-cycle start
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_blocks_start", 32'(busy_proc), 32'd0);

        run_a(4, 4, -1, -1, 0, -1, -1, 1'b0, 1'b0);
        run_a(2, 2, -1, -1, 0, -1, -1, 1'b0, 1'b0);
        run_a(0, 4, -1, -1, 0, -1, -1, 1'b0, 1'b0);
        run_a(5, 4, -1, -1, 0, -1, -1, 1'b0, 1'b0);
        run_a(4, 4,  1, 35, 5, -1, -1, 1'b0, 1'b0);
        run_a(4, 4, -1, -1, 0,  2, 10, 1'b0, 1'b0);
        run_a(4, 4, -1, -1, 0,  2, 10, 1'b1, 1'b0);
        run_a(4, 4, -1, -1, 0, -1, -1, 1'b0, 1'b1);

        // asynchronous reset between clock edges in the middle of RUN
        n_passes_cfg = 3'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", 32'(addr_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_proc), 32'd0);
        check("async_rst_pos", 32'({dir, dir_counter}), 32'd0);
        check("async_rst_valid", 32'(addr_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // small instance: cfg 5 clamps to 3 passes of 5 addresses, no drain
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 5; a++) begin
                se.p = 2'(p);
                se.a = 3'(a);
                s_q.push_back(se);
            end
        end
        s_cfg = 3'd5;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        t0 = cyc;
        fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (s_valid) begin
                if (s_q.size() == 0) begin
                    check("s_extra_addr", 32'(s_valid), 32'd0);
                end else begin
                    se = s_q.pop_front();
                    check("s_addr", 32'({s_dir, s_cnt}), 32'(se));
                    check("s_last_addr", 32'(s_last), 32'(se.a == 3'd4));
                end
            end
            if (s_done) begin
                check("s_done_time", 32'(cyc - t0), 32'd15);
                check("s_done_pos", 32'({s_dir, s_cnt}), 32'd0);
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("s_finished", 32'(fin), 32'd1);
        check("s_queue_empty", 32'(s_q.size()), 32'd0);
        @(negedge clk);
        check("s_post_idle", 32'(s_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
